band_filter: RTL and testbench
==============================

BAND_FILTER -- requirements
Module: band_filter

Interface
REQ-001 Parameter FILTER_IN_BITS, default 16, input sample width (signed two's complement).
REQ-002 Parameter FILTER_OUT_BITS, default 16, output sample width (signed two's complement).
REQ-003 Parameter NUMBER_OF_TAPS, default 16, FIR tap count (>=1).
REQ-004 Parameter COEFF_BITS, default 16, coefficient width (signed, COEFF_BITS-1 fractional bits, i.e. Q1.15 at default).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 clk_enable  input  1  sample strobe; state advances only on rising clk edges where it is high.
REQ-008 filter_in  input  FILTER_IN_BITS  signed input sample.
REQ-009 eff  input  COEFF_BITS*NUMBER_OF_TAPS  packed coefficients; tap k = eff[k*COEFF_BITS +: COEFF_BITS], signed; tap 0 weights the newest sample.
REQ-010 filter_out  output  FILTER_OUT_BITS  signed registered filtered sample.

Function
REQ-011 Block SHALL implement a direct-form FIR: y[n] = sum over k=0..NUMBER_OF_TAPS-1 of c_k * x[n-k], where x[n] is filter_in sampled at the n-th enabled edge.
REQ-012 Delay line SHALL hold NUMBER_OF_TAPS-1 past samples; on each enabled edge it shifts by one and captures filter_in as the newest stored sample.
REQ-013 On each enabled edge filter_out SHALL be loaded with the result computed from the current filter_in and the pre-edge delay-line contents (latency: 1 clock from sample to output).
REQ-014 Products SHALL be full-precision signed (FILTER_IN_BITS+COEFF_BITS bits); accumulator SHALL be FILTER_IN_BITS+COEFF_BITS+ceil(log2(NUMBER_OF_TAPS)) bits, no internal overflow.
REQ-015 Scaling: accumulator + 2^(COEFF_BITS-2), then arithmetic right shift by COEFF_BITS-1 (round half toward +infinity).
REQ-016 Scaled value SHALL saturate to [-2^(FILTER_OUT_BITS-1), 2^(FILTER_OUT_BITS-1)-1]; no wrap-around.
REQ-017 With clk_enable low, delay line and filter_out SHALL hold their values regardless of filter_in or eff changes.
REQ-018 eff SHALL be used combinationally each enabled edge; coefficient change takes effect on the next enabled edge without flushing the delay line.
REQ-019 Consecutive enabled cycles SHALL each accept a new sample (throughput 1 sample/clock).

Reset
REQ-020 While reset_n is low, all delay-line registers and filter_out SHALL be 0, asynchronously, independent of clk and clk_enable.
REQ-021 Reset asserted mid-stream SHALL discard all history; first enabled edge after release computes with zero history.

Verification
REQ-022 Impulse: eff tap k = k*256 (k=0..15), after reset feed 16384 once then 0 -> filter_out sequence 0,128,256,...,1920 then 0.
REQ-023 Rounding: only tap0 = 1; input 16384 -> output 1; input -16384 -> output 0.
REQ-024 Saturation: all taps 0x7FFF, constant input 32767 -> output reaches and holds 32767; constant input -32768 -> holds -32768.
REQ-025 Enable hold: with clk_enable low for 10 cycles while filter_in toggles, filter_out and history unchanged; resumption continues sequence exactly as if no gap.
REQ-026 Reset mid-stream: assert reset_n low during REQ-022 sequence -> filter_out 0 immediately; after release, impulse restarts response from 0.

Source files
------------

// File: rtl/band_filter.sv
// Direct-form FIR with registered, rounded and saturated output.
// One new sample per enabled clock; taps come combinationally from the packed eff bus.
module band_filter #(
    parameter int FILTER_IN_BITS  = 16,
    parameter int FILTER_OUT_BITS = 16,
    parameter int NUMBER_OF_TAPS  = 16,
    parameter int COEFF_BITS      = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 clk_enable,
    input  logic signed [FILTER_IN_BITS-1:0]     filter_in,
    input  logic [COEFF_BITS*NUMBER_OF_TAPS-1:0] eff,
    output logic signed [FILTER_OUT_BITS-1:0]    filter_out
);

    localparam int PROD_BITS = FILTER_IN_BITS + COEFF_BITS;
    localparam int ACC_BITS  = PROD_BITS + $clog2(NUMBER_OF_TAPS);
    localparam int DELAY_LEN = (NUMBER_OF_TAPS > 1) ? NUMBER_OF_TAPS - 1 : 1;
    localparam int SHIFT     = COEFF_BITS - 1;

    localparam logic signed [ACC_BITS-1:0] ROUND_BIAS = ACC_BITS'(1) << (COEFF_BITS - 2);
    localparam logic signed [ACC_BITS-1:0] OUT_MAX    = (ACC_BITS'(1) << (FILTER_OUT_BITS - 1)) - ACC_BITS'(1);
    localparam logic signed [ACC_BITS-1:0] OUT_MIN    = ~OUT_MAX;

    logic signed [FILTER_IN_BITS-1:0]  delay_q [DELAY_LEN];
    logic signed [FILTER_IN_BITS-1:0]  delay_d [DELAY_LEN];
    logic signed [FILTER_OUT_BITS-1:0] filter_out_q;
    logic signed [FILTER_OUT_BITS-1:0] filter_out_d;

    logic signed [FILTER_IN_BITS-1:0] sample;
    logic signed [COEFF_BITS-1:0]     coeff;
    logic signed [PROD_BITS-1:0]      prod;
    logic signed [ACC_BITS-1:0]       acc;
    logic signed [ACC_BITS-1:0]       rounded;
    logic signed [ACC_BITS-1:0]       scaled;

    // Tap 0 sees the live input; tap k sees the (k-1)th stored sample.
    always_comb begin
        sample = '0;
        coeff  = '0;
        prod   = '0;
        acc    = '0;
        for (int k = 0; k < NUMBER_OF_TAPS; k++) begin
            sample = (k == 0) ? filter_in : delay_q[(k > 0) ? k - 1 : 0];
            coeff  = eff[k*COEFF_BITS +: COEFF_BITS];
            prod   = PROD_BITS'(sample) * PROD_BITS'(coeff);
            acc    = acc + ACC_BITS'(prod);
        end
        rounded = acc + ROUND_BIAS;
        scaled  = rounded >>> SHIFT;
    end

    always_comb begin
        filter_out_d = filter_out_q;
        delay_d      = delay_q;
        if (clk_enable) begin
            if (scaled > OUT_MAX) begin
                filter_out_d = OUT_MAX[FILTER_OUT_BITS-1:0];
            end else if (scaled < OUT_MIN) begin
                filter_out_d = OUT_MIN[FILTER_OUT_BITS-1:0];
            end else begin
                filter_out_d = scaled[FILTER_OUT_BITS-1:0];
            end
            if (NUMBER_OF_TAPS > 1) begin
                delay_d[0] = filter_in;
                for (int i = 1; i < DELAY_LEN; i++) begin
                    delay_d[i] = delay_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filter_out_q <= '0;
            for (int i = 0; i < DELAY_LEN; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            filter_out_q <= filter_out_d;
            delay_q      <= delay_d;
        end
    end

    assign filter_out = filter_out_q;

endmodule

// File: tb/tb_band_filter.sv
// Directed self-checking bench for band_filter at default parameters.
// Expected values are hand-derived from the Q1.15 FIR arithmetic.
module tb_band_filter;

    logic               clk;
    logic               reset_n;
    logic               clk_enable;
    logic signed [15:0] filter_in;
    logic [255:0]       eff;
    logic signed [15:0] filter_out;

    int assertions;
    int failures;

    band_filter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_enable (clk_enable),
        .filter_in  (filter_in),
        .eff        (eff),
        .filter_out (filter_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] ramp_taps(input int scale);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'(k * scale);
        return v;
    endfunction

    function automatic logic [255:0] flat_taps(input logic [15:0] c);
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = c;
        return v;
    endfunction

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic signed [15:0] x, input logic en);
        @(negedge clk);
        filter_in  = x;
        clk_enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clk_enable = 1'b0;
        reset_n    = 1'b0;
        #2;
        reset_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic signed [15:0] exp;
        eff = ramp_taps(256);
        step(16'sd16384, 1'b1);
        step(16'sd0, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        exp = 16'sd0;
        assertions++;
        if (filter_out !== exp) begin
            failures++;
            $display("[TB] FAIL reset_async: got %0d expected %0d", filter_out, exp);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_impulse();
        logic signed [15:0] exp;
        eff = ramp_taps(256);
        do_reset();
        for (int n = 0; n < 18; n++) begin
            step((n == 0) ? 16'sd16384 : 16'sd0, 1'b1);
            exp = (n >= 1 && n <= 15) ? 16'(n * 128) : 16'sd0;
            assertions++;
            if (filter_out !== exp) begin
                failures++;
                $display("[TB] FAIL impulse[%0d]: got %0d expected %0d", n, filter_out, exp);
            end
        end
    endtask

    task automatic test_rounding();
        logic signed [15:0] xs  [4];
        logic signed [15:0] exs [4];
        xs  = '{16'sd16384, -16'sd16384, 16'sd16383, -16'sd16385};
        exs = '{16'sd1, 16'sd0, 16'sd0, -16'sd1};
        eff = '0;
        eff[15:0] = 16'd1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(xs[i], 1'b1);
            assertions++;
            if (filter_out !== exs[i]) begin
                failures++;
                $display("[TB] FAIL rounding[%0d] in=%0d: got %0d expected %0d", i, xs[i], filter_out, exs[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] exp;
        eff = flat_taps(16'h7FFF);
        do_reset();
        step(16'sd32767, 1'b1);
        exp = 16'sd32766;
        assertions++;
        if (filter_out !== exp) begin
            failures++;
            $display("[TB] FAIL sat_first: got %0d expected %0d", filter_out, exp);
        end
        for (int n = 0; n < 20; n++) begin
            step(16'sd32767, 1'b1);
            exp = 16'sd32767;
            if (n >= 16) begin
                assertions++;
                if (filter_out !== exp) begin
                    failures++;
                    $display("[TB] FAIL sat_pos[%0d]: got %0d expected %0d", n, filter_out, exp);
                end
            end
        end
        for (int n = 0; n < 20; n++) begin
            step(-16'sd32768, 1'b1);
            exp = -16'sd32768;
            if (n >= 16) begin
                assertions++;
                if (filter_out !== exp) begin
                    failures++;
                    $display("[TB] FAIL sat_neg[%0d]: got %0d expected %0d", n, filter_out, exp);
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        logic signed [15:0] exp;
        eff = ramp_taps(256);
        do_reset();
        for (int n = 0; n < 5; n++) step((n == 0) ? 16'sd16384 : 16'sd0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            filter_in  = 16'($urandom);
            eff        = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            clk_enable = 1'b0;
            @(posedge clk);
            #1;
            exp = 16'sd512;
            assertions++;
            if (filter_out !== exp) begin
                failures++;
                $display("[TB] FAIL hold[%0d]: got %0d expected %0d", c, filter_out, exp);
            end
        end
        eff = ramp_taps(256);
        for (int n = 5; n < 17; n++) begin
            step(16'sd0, 1'b1);
            exp = (n <= 15) ? 16'(n * 128) : 16'sd0;
            assertions++;
            if (filter_out !== exp) begin
                failures++;
                $display("[TB] FAIL resume[%0d]: got %0d expected %0d", n, filter_out, exp);
            end
        end
    endtask

    task automatic test_coeff_change();
        logic signed [15:0] exp;
        eff = ramp_taps(256);
        do_reset();
        step(16'sd16384, 1'b1);
        step(16'sd0, 1'b1);
        eff = ramp_taps(512);
        step(16'sd0, 1'b1);
        exp = 16'sd512;
        assertions++;
        if (filter_out !== exp) begin
            failures++;
            $display("[TB] FAIL coeff_change: got %0d expected %0d", filter_out, exp);
        end
    endtask

    task automatic test_reset_midstream();
        logic signed [15:0] exp;
        eff = ramp_taps(256);
        do_reset();
        for (int n = 0; n < 4; n++) step((n == 0) ? 16'sd16384 : 16'sd0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        exp = 16'sd0;
        assertions++;
        if (filter_out !== exp) begin
            failures++;
            $display("[TB] FAIL mid_reset_now: got %0d expected %0d", filter_out, exp);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(16'sd0, 1'b1);
            assertions++;
            if (filter_out !== exp) begin
                failures++;
                $display("[TB] FAIL mid_reset_hist[%0d]: got %0d expected %0d", n, filter_out, exp);
            end
        end
        for (int n = 0; n < 4; n++) begin
            step((n == 0) ? 16'sd16384 : 16'sd0, 1'b1);
            exp = 16'(n * 128);
            assertions++;
            if (filter_out !== exp) begin
                failures++;
                $display("[TB] FAIL mid_reset_restart[%0d]: got %0d expected %0d", n, filter_out, exp);
            end
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        reset_n    = 1'b0;
        clk_enable = 1'b0;
        filter_in  = '0;
        eff        = '0;
        #3;
        assertions++;
        if (filter_out !== 16'sd0) begin
            failures++;
            $display("[TB] FAIL reset_initial: got %0d expected 0", filter_out);
        end
        #10;
        reset_n = 1'b1;
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_enable_hold();
        test_coeff_change();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
